lfm_burst_scheduler: RTL
========================

Name: lfm_burst_scheduler

Overview:
- Round-robin scheduler that shares the single LFM phase accumulator between N_REQ requesters.
- Each requester presents a complete LFM burst parameter set plus a request line.
- The scheduler validates the winner's parameters and drives them to the accumulator. It pulses the accumulator start, tracks the start-calc/stop-calc handshake to completion, enforces an inter-burst guard gap, and recovers from a stalled accumulator with a watchdog.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle CLK cycles between one burst's stop and the next start (0 allowed).
- TIMEOUT_CYCLES, 32'd4000000000, watchdog limit per burst phase, counted in CLK cycles.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  N_REQ  per-requester request level; held until DONE/REJECT.
- REQ_F_CARRIER  in  32*N_REQ  packed carrier frequencies; requester i at [32i+31:32i].
- REQ_T_IMPULSE  in  10*N_REQ  packed impulse lengths (us).
- REQ_T_PERIOD  in  13*N_REQ  packed periods (us).
- REQ_NUM_OF_IMP  in  5*N_REQ  packed impulse counts.
- REQ_DEVIATION  in  22*N_REQ  packed deviations (Hz).
- GRANT  out  N_REQ  one-hot; the requester currently owning the accumulator.
- DONE  out  N_REQ  1-cycle pulse, burst completed, for the owner.
- REJECT  out  N_REQ  1-cycle pulse, parameter set invalid, no burst issued.
- TIMEOUT_ERR  out  1  1-cycle pulse, watchdog fired.
- BUSY  out  1  high in every state except IDLE.
- F_CARRIER  out  32  to accumulator.
- T_IMPULSE  out  10  to accumulator.
- T_PERIOD  out  13  to accumulator.
- NUM_OF_IMP  out  5  to accumulator.
- DEVIATION  out  22  to accumulator.
- SIGN_START_GEN  out  1  accumulator start request.
- SIGN_START_CALC  in  1  from accumulator: start seen, waiting for output register.
- SIGN_STOP_CALC  in  1  from accumulator: last sample issued.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, counters 0. A reset mid-burst drops SIGN_START_GEN and GRANT the next cycle with no DONE. Resetting the accumulator is the system's job.
- States: IDLE, CHECK, START, ACCEPT, RUN, DRAIN, GAP.
- IDLE: if any REQ is set, pick the first requester at or after the pointer, wrapping modulo N_REQ. Register its five fields onto the output ports and set GRANT one-hot. Go to CHECK. The pointer becomes winner+1 (mod N_REQ), so the winner has lowest priority next time.
- CHECK (1 cycle): a set is invalid if any of these holds:
  - NUM_OF_IMP==0
  - T_IMPULSE==0
  - DEVIATION==0
  - NUM_OF_IMP>1 and T_IMPULSE>=T_PERIOD
  - F_CARRIER < DEVIATION/2 (integer divide)
- CHECK, invalid: pulse REJECT[winner], clear GRANT, go to IDLE.
- CHECK, valid: set SIGN_START_GEN, go to START.
- START: hold SIGN_START_GEN until SIGN_START_CALC==1, then clear SIGN_START_GEN and go to ACCEPT. If SIGN_START_CALC is already 1 on START entry, clear SIGN_START_GEN on the next edge (it is high exactly 1 cycle).
- ACCEPT: wait for SIGN_START_CALC==0 (parameters latched by the accumulator), then go to RUN. Parameter outputs stay frozen from CHECK through end of ACCEPT. They stay unchanged until the next IDLE win.
- RUN: wait for SIGN_STOP_CALC==1, then pulse DONE[winner] and go to DRAIN.
- DRAIN: wait for SIGN_STOP_CALC==0, then clear GRANT and go to GAP. If GAP_CYCLES==0, go straight to IDLE instead.
- GAP: count GAP_CYCLES cycles, then go to IDLE. REQ is ignored during GAP.
- Watchdog: a 32-bit counter clears on every entry to START, ACCEPT, RUN or DRAIN and increments each cycle in those states. When it reaches TIMEOUT_CYCLES:
  - pulse TIMEOUT_ERR;
  - clear SIGN_START_GEN and GRANT;
  - no DONE is issued;
  - go to GAP.
- Requester drop: REQ[winner] falling after CHECK has no effect; the burst runs to completion and DONE still pulses.
- REQ changes in the same cycle as the IDLE decision: the registered REQ value is used; no combinational path from REQ to GRANT.
- SIGN_STOP_CALC and SIGN_START_CALC are both high in one cycle: handle START_CALC first; STOP_CALC is not acted on until RUN.
- All comparisons are unsigned. T_IMPULSE is zero-extended to 13 bits for the period compare.

Test Plan:
- Single request REQ=4'b0001, F=2e9, Ti=60, Tp=360, N=3, Dev=2e6, accumulator model → GRANT=0001; SIGN_START_GEN high until START_CALC; DONE[0] one cycle after STOP_CALC rises; next START no earlier than 16 cycles after STOP_CALC falls.
- REQ=4'b1111 held through 8 bursts → grant order 0,1,2,3,0,1,2,3; each requester receives exactly 2 DONE pulses.
- Requester 2 with NUM_OF_IMP=0 → REJECT[2] 2 cycles after the IDLE win; SIGN_START_GEN never rises; requester 3 is granted next.
- Ti=400, Tp=360, N=2 → REJECT. Same Ti/Tp with N=1 → accepted and burst runs.
- Model never asserts START_CALC, TIMEOUT_CYCLES=100 → TIMEOUT_ERR exactly 100 cycles after START entry; GRANT=0; IDLE after the gap.
- RESET asserted during RUN → next cycle GRANT=0, BUSY=0, SIGN_START_GEN=0, no DONE; a fresh request is served normally afterwards.

Source files
------------

// File: rtl/lfm_burst_scheduler.sv
// Round-robin arbiter sharing one LFM phase accumulator between N_REQ requesters:
// validates the winner's burst parameters, runs the start/stop handshake, guard gap and watchdog.
module lfm_burst_scheduler #(
  parameter int          N_REQ          = 4,
  parameter int          GAP_CYCLES     = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [32*N_REQ-1:0] REQ_F_CARRIER,
  input  logic [10*N_REQ-1:0] REQ_T_IMPULSE,
  input  logic [13*N_REQ-1:0] REQ_T_PERIOD,
  input  logic [5*N_REQ-1:0]  REQ_NUM_OF_IMP,
  input  logic [22*N_REQ-1:0] REQ_DEVIATION,
  output logic [N_REQ-1:0]    GRANT,
  output logic [N_REQ-1:0]    DONE,
  output logic [N_REQ-1:0]    REJECT,
  output logic                TIMEOUT_ERR,
  output logic                BUSY,
  output logic [31:0]         F_CARRIER,
  output logic [9:0]          T_IMPULSE,
  output logic [12:0]         T_PERIOD,
  output logic [4:0]          NUM_OF_IMP,
  output logic [21:0]         DEVIATION,
  output logic                SIGN_START_GEN,
  input  logic                SIGN_START_CALC,
  input  logic                SIGN_STOP_CALC
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_ACCEPT = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_GAP    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, win_q, win_d;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d, reject_q, reject_d;
  logic             timeout_q, timeout_d, start_gen_q, start_gen_d;
  logic [31:0]      wd_q, wd_d, gap_q, gap_d;
  logic [31:0]      f_q, f_d;
  logic [9:0]       ti_q, ti_d;
  logic [12:0]      tp_q, tp_d;
  logic [4:0]       n_q, n_d;
  logic [21:0]      dv_q, dv_d;

  logic             found;
  logic [PW-1:0]    pick;
  logic [PW:0]      sum;
  logic             wd_expired;
  logic             gap_next;

  function automatic logic param_valid(input logic [31:0] f, input logic [9:0] ti,
                                       input logic [12:0] tp, input logic [4:0] n,
                                       input logic [21:0] dv);
    logic bad;
    bad = (n == 5'd0) || (ti == 10'd0) || (dv == 22'd0);
    bad = bad || ((n > 5'd1) && ({3'b000, ti} >= tp));
    bad = bad || (f < {11'b0, dv[21:1]});
    return !bad;
  endfunction

  // First requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      if (!found && REQ[sum[PW-1:0]]) begin
        found = 1'b1;
        pick  = sum[PW-1:0];
      end
    end
  end

  assign wd_expired = ({1'b0, wd_q} + 33'd1) == {1'b0, TIMEOUT_CYCLES};
  assign gap_next   = (GAP_CYCLES == 0);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    grant_d     = grant_q;
    done_d      = '0;
    reject_d    = '0;
    timeout_d   = 1'b0;
    start_gen_d = start_gen_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    f_d         = f_q;
    ti_d        = ti_q;
    tp_d        = tp_q;
    n_d         = n_q;
    dv_d        = dv_q;
    case (state_q)
      S_IDLE: begin
        // REQ is sampled at the edge; GRANT is a flop, so no combinational path.
        if (found) begin
          win_d   = pick;
          ptr_d   = (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          grant_d = '0;
          for (int i = 0; i < N_REQ; i++) begin
            if (PW'(i) == pick) begin
              grant_d[i] = 1'b1;
              f_d        = REQ_F_CARRIER[32*i +: 32];
              ti_d       = REQ_T_IMPULSE[10*i +: 10];
              tp_d       = REQ_T_PERIOD[13*i +: 13];
              n_d        = REQ_NUM_OF_IMP[5*i +: 5];
              dv_d       = REQ_DEVIATION[22*i +: 22];
            end
          end
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (param_valid(f_q, ti_q, tp_q, n_q, dv_q)) begin
          start_gen_d = 1'b1;
          wd_d        = '0;
          state_d     = S_START;
        end else begin
          reject_d[win_q] = 1'b1;
          grant_d         = '0;
          state_d         = S_IDLE;
        end
      end
      S_START, S_ACCEPT, S_RUN, S_DRAIN: begin
        if (wd_expired) begin
          timeout_d   = 1'b1;
          start_gen_d = 1'b0;
          grant_d     = '0;
          wd_d        = '0;
          gap_d       = '0;
          state_d     = gap_next ? S_IDLE : S_GAP;
        end else begin
          wd_d = wd_q + 32'd1;
          case (state_q)
            S_START: if (SIGN_START_CALC) begin
              start_gen_d = 1'b0;
              wd_d        = '0;
              state_d     = S_ACCEPT;
            end
            S_ACCEPT: if (!SIGN_START_CALC) begin
              wd_d    = '0;
              state_d = S_RUN;
            end
            S_RUN: if (SIGN_STOP_CALC) begin
              done_d[win_q] = 1'b1;
              wd_d          = '0;
              state_d       = S_DRAIN;
            end
            default: if (!SIGN_STOP_CALC) begin
              grant_d = '0;
              gap_d   = '0;
              state_d = gap_next ? S_IDLE : S_GAP;
            end
          endcase
        end
      end
      S_GAP: begin
        if (gap_q == 32'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else gap_d = gap_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      reject_q    <= '0;
      timeout_q   <= 1'b0;
      start_gen_q <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
      f_q         <= '0;
      ti_q        <= '0;
      tp_q        <= '0;
      n_q         <= '0;
      dv_q        <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
      timeout_q   <= timeout_d;
      start_gen_q <= start_gen_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      f_q         <= f_d;
      ti_q        <= ti_d;
      tp_q        <= tp_d;
      n_q         <= n_d;
      dv_q        <= dv_d;
    end
  end

  assign GRANT          = grant_q;
  assign DONE           = done_q;
  assign REJECT         = reject_q;
  assign TIMEOUT_ERR    = timeout_q;
  assign BUSY           = (state_q != S_IDLE);
  assign SIGN_START_GEN = start_gen_q;
  assign F_CARRIER      = f_q;
  assign T_IMPULSE      = ti_q;
  assign T_PERIOD       = tp_q;
  assign NUM_OF_IMP     = n_q;
  assign DEVIATION      = dv_q;

endmodule
